// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg -- shared types and helpers for the 68000 bus arbiter.
//   arb_state_t : arbiter FSM states
//   OWNER_*     : encodings driven on the Owner port
//   cnt_width() : bit width needed to hold a counter value 0..max_val
package bus_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_FREE,
    GRANT,
    RELEASE
  } arb_state_t;

  localparam logic [1:0] OWNER_CPU = 2'b00;
  localparam logic [1:0] OWNER_DMA = 2'b01;
  localparam logic [1:0] OWNER_GFX = 2'b10;

  function automatic int cnt_width(input int max_val);
    if (max_val < 2) return 1;
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/bus_arb_rr_pick.sv
// bus_arb_rr_pick -- two-way round-robin winner selection (combinational).
//   i_dma_req  : DMA request, active high
//   i_gfx_req  : graphics request, active high
//   i_last_gfx : 1 = graphics held the previous tenure, 0 = DMA did
//   o_dma_win  : DMA wins (one-hot with o_gfx_win, both 0 when nobody asks)
//   o_gfx_win  : graphics wins
module bus_arb_rr_pick (
  input  logic i_dma_req,
  input  logic i_gfx_req,
  input  logic i_last_gfx,
  output logic o_dma_win,
  output logic o_gfx_win
);

  // On a tie the master that did not hold the previous tenure wins.
  assign o_dma_win = i_dma_req & (~i_gfx_req | i_last_gfx);
  assign o_gfx_win = i_gfx_req & (~i_dma_req | ~i_last_gfx);

endmodule

// File: rtl/bus_arbiter_68k.sv
// bus_arbiter_68k -- shares the 68000 bus between the CPU, the DMA controller
// and the graphics engine using the BR/BG/BGACK handshake.
// Ports (all active-low unless noted, all synchronous to Clk):
//   Clk, Reset_L (async)       : clock and reset
//   DmaReq_L, GfxReq_L         : alternate-master bus requests
//   AS_L, DTACK_L, BG_L        : CPU bus status and bus grant
//   BR_L, BGACK_L              : bus request / grant acknowledge to the CPU
//   DmaGrant_L, GfxGrant_L     : bus ownership strobes to the masters
//   Owner[1:0]                 : 00 CPU, 01 DMA, 10 GFX (active high)
//   TenureExpired_H            : one-cycle pulse on a forced release
// Optional feature: define TENURE_LIMIT_EN to bound each tenure to MAX_TENURE
// GRANT cycles; without it TenureExpired_H is tied low.
module bus_arbiter_68k
  import bus_arb_pkg::*;
#(
  parameter int CPU_GAP    = 4,
  parameter int MAX_TENURE = 256
) (
  input  logic       Clk,
  input  logic       Reset_L,
  input  logic       DmaReq_L,
  input  logic       GfxReq_L,
  input  logic       AS_L,
  input  logic       DTACK_L,
  input  logic       BG_L,
  output logic       BR_L,
  output logic       BGACK_L,
  output logic       DmaGrant_L,
  output logic       GfxGrant_L,
  output logic [1:0] Owner,
  output logic       TenureExpired_H
);

  if (CPU_GAP < 1 || CPU_GAP > 255 || MAX_TENURE < 2 || MAX_TENURE > 65535) begin : g_param_check
    $error("bus_arbiter_68k: CPU_GAP or MAX_TENURE out of range");
  end

  localparam int GAP_W = cnt_width(CPU_GAP - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(CPU_GAP - 1);

  arb_state_t       r_state;
  logic             r_br_l;
  logic             r_bgack_l;
  logic             r_dma_grant_l;
  logic             r_gfx_grant_l;
  logic [1:0]       r_owner;
  logic             r_last_gfx;
  logic [GAP_W-1:0] r_gap_cnt;

  logic w_dma_req;
  logic w_gfx_req;
  logic w_any_req;
  logic w_dma_win;
  logic w_gfx_win;
  logic w_winner_req;
  logic w_force_release;

  assign w_dma_req = ~DmaReq_L;
  assign w_gfx_req = ~GfxReq_L;
  assign w_any_req = w_dma_req | w_gfx_req;

  // During GRANT only the current owner's request matters.
  assign w_winner_req = (r_owner == OWNER_DMA) ? w_dma_req : w_gfx_req;

  bus_arb_rr_pick u_rr_pick (
    .i_dma_req (w_dma_req),
    .i_gfx_req (w_gfx_req),
    .i_last_gfx(r_last_gfx),
    .o_dma_win (w_dma_win),
    .o_gfx_win (w_gfx_win)
  );

`ifdef TENURE_LIMIT_EN
  localparam int TEN_W = cnt_width(MAX_TENURE - 1);
  localparam logic [TEN_W-1:0] TEN_LAST = TEN_W'(MAX_TENURE - 1);

  logic [TEN_W-1:0] r_ten_cnt;
  logic             r_tenure_expired;

  // Never cut a tenure while a bus cycle is in flight.
  assign w_force_release = (r_ten_cnt == TEN_LAST) & AS_L;
  assign TenureExpired_H = r_tenure_expired;
`else
  assign w_force_release = 1'b0;
  assign TenureExpired_H = 1'b0;
`endif

  always_ff @(posedge Clk or negedge Reset_L) begin
    if (!Reset_L) begin
      r_state       <= IDLE;
      r_br_l        <= 1'b1;
      r_bgack_l     <= 1'b1;
      r_dma_grant_l <= 1'b1;
      r_gfx_grant_l <= 1'b1;
      r_owner       <= OWNER_CPU;
      r_last_gfx    <= 1'b1;       // DMA wins the first tie
      r_gap_cnt     <= '0;
`ifdef TENURE_LIMIT_EN
      r_ten_cnt        <= '0;
      r_tenure_expired <= 1'b0;
`endif
    end else begin
`ifdef TENURE_LIMIT_EN
      r_tenure_expired <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_state <= REQ;
            r_br_l  <= 1'b0;
          end
        end

        REQ: begin
          if (!w_any_req) begin
            r_state <= IDLE;
            r_br_l  <= 1'b1;
          end else if (!BG_L) begin
            r_state <= WAIT_FREE;
          end
        end

        WAIT_FREE: begin
          // Withdrawal takes priority over the bus becoming free.
          if (!w_any_req) begin
            r_state <= IDLE;
            r_br_l  <= 1'b1;
          end else if (!BG_L && AS_L && DTACK_L) begin
            r_state       <= GRANT;
            r_br_l        <= 1'b1;
            r_bgack_l     <= 1'b0;
            r_dma_grant_l <= ~w_dma_win;
            r_gfx_grant_l <= ~w_gfx_win;
            r_owner       <= w_dma_win ? OWNER_DMA : OWNER_GFX;
`ifdef TENURE_LIMIT_EN
            r_ten_cnt     <= '0;
`endif
          end
        end

        GRANT: begin
`ifdef TENURE_LIMIT_EN
          if (r_ten_cnt != TEN_LAST) r_ten_cnt <= r_ten_cnt + 1'b1;
`endif
          if (!w_winner_req || w_force_release) begin
            r_state       <= RELEASE;
            r_bgack_l     <= 1'b1;
            r_dma_grant_l <= 1'b1;
            r_gfx_grant_l <= 1'b1;
            r_owner       <= OWNER_CPU;
            r_last_gfx    <= (r_owner == OWNER_GFX);
            r_gap_cnt     <= GAP_LOAD;
`ifdef TENURE_LIMIT_EN
            // Only a release the owner did not ask for counts as expired.
            r_tenure_expired <= w_winner_req;
`endif
          end
        end

        RELEASE: begin
          if (r_gap_cnt == '0) r_state <= IDLE;
          else                 r_gap_cnt <= r_gap_cnt - 1'b1;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign BR_L       = r_br_l;
  assign BGACK_L    = r_bgack_l;
  assign DmaGrant_L = r_dma_grant_l;
  assign GfxGrant_L = r_gfx_grant_l;
  assign Owner      = r_owner;

endmodule
